// File: rtl/mult8_seg_top_if.sv
// mult8_seg_top_if
//   Bundles the multiplier handshake and the display scan output.
//   master : drives start/a/b, observes d_out/done_flag/seg_position (bench or host)
//   slave  : the mult8_seg_top block itself
// Signals:
//   start        level request to begin a multiply (sampled only when idle)
//   a, b         8-bit unsigned operands
//   d_out        16-bit product of the last completed operation
//   done_flag    one-cycle pulse when d_out has just been updated
//   seg_position active-low one-hot digit select for the 7-segment display
interface mult8_seg_top_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] d_out;
    logic        done_flag;
    logic [7:0]  seg_position;

    modport master (
        output start, a, b,
        input  d_out, done_flag, seg_position
    );

    modport slave (
        input  start, a, b,
        output d_out, done_flag, seg_position
    );
endinterface

// File: rtl/mult8_seg_top.sv
// mult8_seg_top
//   Sequential 8x8 unsigned shift-and-add multiplier with a one-cycle
//   done pulse, plus a free-running digit-select scanner for the board's
//   multiplexed 7-segment display.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high; aborts any operation in flight
//   bus  mult8_seg_top_if.slave (start, a, b -> d_out, done_flag, seg_position)
// Parameters:
//   SCAN_DIV  clock cycles per seg_position step (>= 1)
// Timing (edge that samples start=1 is edge 1):
//   edges 2..9 accumulate, edge 10 commits d_out and raises done_flag,
//   edge 11 returns to IDLE, so a held start re-captures every 11 cycles.
module mult8_seg_top #(
    parameter int SCAN_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mult8_seg_top_if.slave        bus
);

    // ------------------------------------------------------------------
    // Multiplier FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q,  state_d;
    logic [15:0] mcand_q,  mcand_d;   // multiplicand, shifts left each step
    logic [7:0]  mplier_q, mplier_d;  // multiplier, shifts right each step
    logic [15:0] acc_q,    acc_d;
    logic [3:0]  cnt_q,    cnt_d;     // completed accumulate steps, 0..8
    logic [15:0] d_out_q,  d_out_d;
    logic        done_q,   done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            d_out_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            d_out_q  <= d_out_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        d_out_d  = d_out_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mcand_d  = {8'h00, bus.a};
                    mplier_d = bus.b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_BUSY;
                end
            end

            S_BUSY: begin
                if (cnt_q == 4'd8) begin
                    // All eight partial products are in; commit on this edge
                    // so d_out and done_flag appear together in DONE.
                    d_out_d = acc_q;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    // Product max is 0xFE01, so the 16-bit add never wraps.
                    if (mplier_q[0])
                        acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 4'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.d_out     = d_out_q;
    assign bus.done_flag = done_q;

    // ------------------------------------------------------------------
    // Display digit scanner
    // ------------------------------------------------------------------
    // Width guard keeps the prescaler at least one bit wide when SCAN_DIV=1;
    // in that case it stays at 0 and the scan steps every cycle.
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [7:0]    seg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            seg_q   <= 8'hFE;
        end else if (presc_q == PRESC_MAX) begin
            presc_q <= '0;
            seg_q   <= {seg_q[6:0], seg_q[7]};
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    assign bus.seg_position = seg_q;

endmodule

// File: tb/tb_mult8_seg_top.sv
// tb_mult8_seg_top
//   Directed bench for mult8_seg_top with SCAN_DIV=4. Expected products are
//   hand-computed constants; seg_position is checked every cycle against a
//   rotation derived from the number of edges since the last reset.
module tb_mult8_seg_top;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult8_seg_top_if bus();

    mult8_seg_top #(.SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // ---------------- seg_position model ----------------
    int k = 0;       // edges since last reset edge
    bit seg_chk = 0;

    function automatic logic [7:0] seg_exp(input int n);
        logic [7:0] v;
        v = 8'hFE;
        for (int i = 0; i < (n / 4) % 8; i++)
            v = {v[6:0], v[7]};
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    always @(negedge clk) begin
        if (seg_chk) begin
            chk("seg_pos", {8'h00, bus.seg_position}, {8'h00, seg_exp(k)});
            chk("seg_onehot", 16'($countones(~bus.seg_position)), 16'd1);
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_done(input int max, output int n, output bit hit);
        n   = 0;
        hit = 0;
        while (n < max && !hit) begin
            @(negedge clk);
            n++;
            if (bus.done_flag === 1'b1) hit = 1;
        end
    endtask

    // One start pulse, then cycle-exact check of the done pulse and result.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] exp, input string tag);
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (i < 10) begin
                chk({tag, "_early_done"}, {15'd0, bus.done_flag}, 16'd0);
            end else if (i == 10) begin
                chk({tag, "_done"}, {15'd0, bus.done_flag}, 16'd1);
                chk({tag, "_dout"}, bus.d_out, exp);
            end else begin
                chk({tag, "_done_clr"}, {15'd0, bus.done_flag}, 16'd0);
                chk({tag, "_dout_hold"}, bus.d_out, exp);
            end
        end
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done_flag === 1'b1) cnt++;
        end
    endtask

    logic [7:0]  va   [4] = '{8'hF0, 8'h0F, 8'hFF, 8'hFF};
    logic [7:0]  vb   [4] = '{8'h35, 8'h44, 8'h00, 8'hF1};
    logic [15:0] vexp [4] = '{16'h31B0, 16'h03FC, 16'h0000, 16'hF00F};

    initial begin
        int  n;
        bit  hit;
        int  cnt;

        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_dout", bus.d_out, 16'h0000);
        chk("rst_done", {15'd0, bus.done_flag}, 16'd0);
        chk("rst_seg", {8'h00, bus.seg_position}, 16'h00FE);
        rst     = 1'b0;
        seg_chk = 1;

        // Single pulse: 0x81 * 0x13
        run_op(8'h81, 8'h13, 16'h0993, "op1");
        repeat (5) @(negedge clk);
        chk("op1_hold_dout", bus.d_out, 16'h0993);
        chk("op1_hold_done", {15'd0, bus.done_flag}, 16'd0);

        // Held start with operands changing between operations
        bus.a     = va[0];
        bus.b     = vb[0];
        bus.start = 1'b1;
        for (int v = 0; v < 4; v++) begin
            wait_done(25, n, hit);
            chk("held_done_seen", {15'd0, hit}, 16'd1);
            chk("held_dout", bus.d_out, vexp[v]);
            chk("held_period", 16'(n), (v == 0) ? 16'd10 : 16'd11);
            if (v < 3) begin
                bus.a = va[v + 1];
                bus.b = vb[v + 1];
            end else begin
                bus.start = 1'b0;
            end
        end
        @(negedge clk);
        chk("held_done_clr", {15'd0, bus.done_flag}, 16'd0);
        count_done(14, cnt);
        chk("held_no_extra", 16'(cnt), 16'd0);

        // Corner operands
        run_op(8'hFF, 8'hFF, 16'hFE01, "ffxff");
        run_op(8'h00, 8'hFF, 16'h0000, "00xff");
        run_op(8'h01, 8'h80, 16'h0080, "01x80");

        // Operand changes and start toggling while busy
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        bus.start = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            case (i)
                1: begin bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b0; end
                3: bus.start = 1'b1;
                5: bus.start = 1'b0;
                7: bus.start = 1'b1;
                8: bus.start = 1'b0;
                default: ;
            endcase
            if (i < 9) chk("tog_early_done", {15'd0, bus.done_flag}, 16'd0);
        end
        @(negedge clk);
        chk("tog_done", {15'd0, bus.done_flag}, 16'd1);
        chk("tog_dout", bus.d_out, 16'h03A8);
        count_done(15, cnt);
        chk("tog_no_extra", 16'(cnt), 16'd0);
        chk("tog_dout_hold", bus.d_out, 16'h03A8);

        // Reset in the middle of BUSY
        bus.a     = 8'h55;
        bus.b     = 8'h03;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_dout", bus.d_out, 16'h0000);
        chk("midrst_done", {15'd0, bus.done_flag}, 16'd0);
        count_done(12, cnt);
        chk("midrst_no_done", 16'(cnt), 16'd0);
        chk("midrst_dout_hold", bus.d_out, 16'h0000);
        run_op(8'h0A, 8'h0B, 16'h006E, "post_rst");

        // Let the scanner run through a full rotation and beyond
        repeat (40) @(negedge clk);
        seg_chk = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
